// File: rtl/pulse_stimulus_pkg.sv
// Shared types and constants for the pulse stimulus generator and its jitter LFSR.
package pulse_stimulus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int DEFAULT_CNT_W = 8;

    // Fibonacci LFSR, taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/pulse_stimulus_gen_lfsr16.sv
// 16-bit Fibonacci LFSR used to jitter gap lengths; only built when
// PULSE_STIMULUS_GEN_JITTER_EN is defined, so the default build carries no LFSR.
`ifdef PULSE_STIMULUS_GEN_JITTER_EN
module lfsr16
    import pulse_stimulus_pkg::*;
(
    input  logic        clk_i,
    input  logic        n_reset_i,
    input  logic        advance_i,
    output logic [15:0] state_o
);

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        feedback;

    always_comb begin
        feedback = ^(state_q & LFSR_TAPS);
        state_d  = {state_q[14:0], feedback};
    end

    always_ff @(posedge clk_i) begin
        if (!n_reset_i) begin
            state_q <= LFSR_SEED;
        end else if (advance_i) begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`endif

// File: rtl/pulse_stimulus_gen.sv
// Burst pulse generator: accepts {width, gap, count} over valid/ready and drives
// pulses on signal_out. Optional gap jitter is enabled by PULSE_STIMULUS_GEN_JITTER_EN.
module pulse_stimulus_gen
    import pulse_stimulus_pkg::*;
#(
    parameter int   CNT_W      = DEFAULT_CNT_W,
    parameter logic IDLE_LEVEL = 1'b1
)
(
    input  logic             clk,
    input  logic             n_reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_width,
    input  logic [CNT_W-1:0] req_gap,
    input  logic [CNT_W-1:0] req_count,
    output logic             signal_out,
    output logic             busy,
    output logic             done
);

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high exactly while the FSM sits in IDLE, and req_* are latched then.

`ifdef PULSE_STIMULUS_GEN_JITTER_EN
    localparam int GAP_W = CNT_W + 1;
`else
    localparam int GAP_W = CNT_W;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] width_q;
    logic [CNT_W-1:0] gap_base_q;
    logic [CNT_W-1:0] width_cnt_q;
    logic [CNT_W-1:0] pulse_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             signal_q;
    logic             busy_q;
    logic             done_q;

    logic [CNT_W-1:0] acc_gap_eff;
    logic [CNT_W-1:0] acc_count_eff;
    logic [CNT_W-1:0] gap_eff_sel;
    logic [GAP_W-1:0] gap_len;
    logic             gap_enter;

    always_comb begin
        acc_gap_eff   = (req_gap == '0)   ? CNT_ONE : req_gap;
        acc_count_eff = (req_count == '0) ? CNT_ONE : req_count;
        // In IDLE the gap is loaded straight from the request, before gap_base_q is valid.
        gap_eff_sel   = (state_q == IDLE) ? acc_gap_eff : gap_base_q;
    end

    always_comb begin
        gap_enter = 1'b0;
        case (state_q)
            IDLE:    gap_enter = req_valid && (req_width == '0);
            PULSE:   gap_enter = (width_cnt_q == CNT_ONE);
            GAP:     gap_enter = (gap_cnt_q == GAP_ONE) && (pulse_cnt_q != CNT_ONE)
                                 && (width_q == '0);
            default: gap_enter = 1'b0;
        endcase
    end

`ifdef PULSE_STIMULUS_GEN_JITTER_EN
    logic [15:0] lfsr_state;

    lfsr16 u_lfsr16 (
        .clk_i     (clk),
        .n_reset_i (n_reset),
        .advance_i (gap_enter),
        .state_o   (lfsr_state)
    );

    assign gap_len = GAP_W'(gap_eff_sel) + GAP_W'(lfsr_state[3:0]);
`else
    assign gap_len = gap_eff_sel;
`endif

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            width_q     <= '0;
            gap_base_q  <= '0;
            width_cnt_q <= '0;
            pulse_cnt_q <= '0;
            gap_cnt_q   <= '0;
            signal_q    <= IDLE_LEVEL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        width_q     <= req_width;
                        gap_base_q  <= acc_gap_eff;
                        pulse_cnt_q <= acc_count_eff;
                        busy_q      <= 1'b1;
                        if (req_width != '0) begin
                            state_q     <= PULSE;
                            width_cnt_q <= req_width;
                            signal_q    <= ~IDLE_LEVEL;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= gap_len;
                        end
                    end
                end
                PULSE: begin
                    if (width_cnt_q == CNT_ONE) begin
                        state_q     <= GAP;
                        width_cnt_q <= '0;
                        gap_cnt_q   <= gap_len;
                        signal_q    <= IDLE_LEVEL;
                    end else begin
                        width_cnt_q <= width_cnt_q - CNT_ONE;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_ONE) begin
                        if (pulse_cnt_q == CNT_ONE) begin
                            state_q     <= IDLE;
                            pulse_cnt_q <= '0;
                            gap_cnt_q   <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            pulse_cnt_q <= pulse_cnt_q - CNT_ONE;
                            if (width_q != '0) begin
                                state_q     <= PULSE;
                                width_cnt_q <= width_q;
                                signal_q    <= ~IDLE_LEVEL;
                            end else begin
                                // Zero-width bursts chain gap phases back to back.
                                gap_cnt_q <= gap_len;
                            end
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_ONE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    signal_q <= IDLE_LEVEL;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign signal_out = signal_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/pulse_stimulus_gen.md
Name: pulse_stimulus_gen

Overview:
Test-harness pulse generator: the driving end of the glitch-filter path. It accepts a request over a valid/ready handshake, then drives a burst of active-level pulses on signal_out, with programmed width, gap and count. signal_out idles at IDLE_LEVEL (default 1), which matches the filter's reset level. Used to inject both sub-threshold glitches and qualifying edges into the delay-line filter input.

Parameters:
CNT_W, 8, width of the req_width, req_gap and req_count fields and of the internal counters
IDLE_LEVEL, 1, level of signal_out when idle, in gaps and in reset; the pulse level is its inverse

Ports:
clk  input  1  system clock, all logic on rising edge
n_reset  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  1  request present
req_ready  output  1  generator can accept a request; high only in IDLE
req_width  input  CNT_W  pulse width in clk cycles
req_gap  input  CNT_W  idle cycles after each pulse
req_count  input  CNT_W  pulses per burst
signal_out  output  1  generated waveform, registered
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle strobe when a burst completes

Behaviour:
- Reset (n_reset=0 at an edge): state=IDLE, signal_out=IDLE_LEVEL, done=0, busy=0, counters=0. Reset mid-burst aborts the burst; done is not asserted.
- req_ready = (state==IDLE), combinational from state. The request is accepted at the edge where req_valid && req_ready. At acceptance, req_* are latched; later changes to the inputs are ignored.
- Effective values:
  - count_eff = (req_count==0) ? 1 : req_count
  - gap_eff = (req_gap==0) ? 1 : req_gap, so consecutive pulses never merge
- States:
  - IDLE -> PULSE on accept with width!=0.
  - IDLE -> GAP on accept with width==0. No pulse is driven; signal_out stays idle for the gap phases.
  - PULSE: signal_out=~IDLE_LEVEL for exactly req_width cycles. The first active cycle is the cycle after the accept edge. Then -> GAP.
  - GAP: signal_out=IDLE_LEVEL for gap_eff cycles.
    - If pulses remain: -> PULSE (or GAP again if width==0).
    - Otherwise: -> IDLE.
- done=1 for exactly the first IDLE cycle after the final gap. req_ready is also 1 in that cycle, so back-to-back accepts are allowed. A new burst accepted in that cycle starts its pulse on the following cycle.
- Burst duration from the accept edge to the done cycle = count_eff*(req_width+gap_eff) cycles; done is in cycle +1 after that.
- Counters:
  - Width counter counts down from the latched value.
  - Pulse counter decrements at each GAP exit.
  - No wrap: width=2^CNT_W-1 is a legal maximum.
- All outputs except req_ready are registered.

Optional Feature:
Macro PULSE_STIMULUS_GEN_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per GAP entry.
  - The gap length becomes gap_eff + lfsr[3:0].
  - The LFSR state is held otherwise.
  - The done timing formula is then valid only when lfsr[3:0] is included.
- Undefined: no LFSR logic; gap length is exactly gap_eff.

Decomposition:
- Shared package pulse_stimulus_pkg:
  - state enum (IDLE, PULSE, GAP)
  - LFSR seed and tap constants
  - default CNT_W
- Sub-module lfsr16: advance enable input, 16-bit state output. Instantiated only under PULSE_STIMULUS_GEN_JITTER_EN.

Test Plan:
- Reset held 3 cycles, then released with req_valid=0 -> signal_out=1, req_ready=1, busy=0, done=0.
- Accept width=5, gap=3, count=1 -> signal_out=0 on cycles 1..5 after accept, 1 on cycles 6..8, done=1 on cycle 9. A downstream glitch filter with DELAY=10 keeps its output at 1.
- Accept width=12, gap=12, count=2 -> two 12-cycle low pulses separated by 12 high cycles, done on cycle 49. A filter with DELAY=10 output goes low twice.
- Accept width=4, gap=0, count=0 -> gap_eff=1, count_eff=1: 4 low cycles, 1 high cycle, done on cycle 6.
- Assert n_reset=0 during the PULSE of a width=20 burst -> signal_out=1 at the next edge, state IDLE, no done. A new request is accepted right after reset release.
- With the macro defined: width=2, gap=1, count=3 -> gaps equal 1+lfsr[3:0], matching a reference LFSR model seeded 16'hACE1.
